mul_scheduler: RTL and testbench
================================

Name: mul_scheduler

Overview:
- Shares one sequential 32x32 shift-add multiplier between two requesters.
- Arbitrates pending requests and loads the granted requester's operands into the multiplier.
- Runs the multiplier until it reports ready, then returns the 64-bit product to the granted requester only.
- Includes a watchdog that aborts a run if the multiplier never reports ready.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH.
- TIMEOUT, 40, max cycles in RUN before abort; must exceed WIDTH+1.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- req0  input  1  requester 0 request; held with stable operands until done0
- a0  input  WIDTH  requester 0 multiplicand
- b0  input  WIDTH  requester 0 multiplier
- done0  output  1  one-cycle pulse: product0/err valid for requester 0
- product0  output  2*WIDTH  requester 0 result, held until next done0
- req1, a1, b1, done1, product1: same as requester 0, for requester 1
- err  output  1  valid with a done pulse; 1 = aborted by timeout, product forced 0
- busy  output  1  high in any state other than IDLE
- mul_load  output  1  one-cycle pulse: shared unit loads mul_a/mul_b and clears its counter
- mul_a  output  WIDTH  operand A to shared unit
- mul_b  output  WIDTH  operand B to shared unit
- mul_run  output  1  shared unit iterates while high
- mul_ready  input  1  shared unit finished; product valid
- mul_product  input  2*WIDTH  shared unit result

Behaviour:
- Reset values (asynchronous): all outputs 0, state IDLE, last_grant=1 (so requester 0 wins first tie), wd counter 0.
- FSM states and transitions:
  - IDLE: if any req, latch grant; go LOAD.
  - LOAD, 1 cycle: mul_load=1; mul_a/mul_b driven from the granted requester's operands and registered for the whole transaction; go RUN.
  - RUN: mul_run=1; wd increments each cycle.
    - If mul_ready=1: capture mul_product into product of the grant, err=0; go DONE.
    - Else if wd reaches TIMEOUT-1: product of the grant = 0, err=1; go DONE.
    - mul_ready takes priority over timeout in the same cycle.
  - DONE, 1 cycle: done of the grant=1; mul_run=0; last_grant=grant; wd=0; go IDLE.
- Arbitration, sampled in IDLE only:
  - Only req0 or only req1 high: that one is granted.
  - Both high: the requester not equal to last_grant is granted (round-robin).
- Latency:
  - One-cycle request: req sampled in IDLE cycle t; mul_load at t+1; mul_run from t+2.
  - With mul_ready first seen at cycle r, done pulses at r+1.
  - Minimum IDLE-to-done: 4 cycles with an immediate ready.
- Request rules:
  - A req dropped before its done is ignored once granted; the transaction completes and done still pulses.
  - A req still high in the IDLE cycle after done counts as a new request.
- Outputs:
  - The non-granted product register is never modified.
  - err holds its value until the next done.
  - busy=0 only in IDLE.
- Back-to-back: both requesters continuously requesting alternate grants 0,1,0,1…
- Reset mid-transaction: aborts immediately to IDLE with outputs 0; no done pulse; shared unit sees mul_run=0.

Optional Feature:
- Macro: MUL_SCHED_FIXED_PRIO_EN.
- When defined: fixed priority, req0 always wins when both are high; last_grant unused.
- When undefined: round-robin as above.

Test Plan:
- Single req0, a0=7, b0=6, model ready after 33 RUN cycles -> mul_load 1 cycle later with mul_a=7, mul_b=6; done0 pulses once; product0=42; err=0; done1 never asserts.
- req0 and req1 asserted in the same cycle out of reset (a0=3,b0=5; a1=0xFFFFFFFF,b1=2) -> requester 0 served first (product0=15), then requester 1 (product1=0x1_FFFF_FFFE).
- Both requests held high for 4 transactions -> grant order 0,1,0,1; with MUL_SCHED_FIXED_PRIO_EN -> 0,0,0,0.
- mul_ready never asserted, TIMEOUT=40 -> done pulses exactly 40 RUN cycles after the first mul_run cycle; err=1; product=0; busy returns 0 next cycle.
- Reset asserted mid-RUN -> all outputs 0 that same cycle; no done; the next req is served normally with last_grant reset behaviour.
- mul_ready asserted on the same cycle as the timeout expiry -> err=0; product = mul_product.

Source files
------------

// File: rtl/mul_scheduler.sv
// Shares one sequential WIDTH x WIDTH multiplier between two requesters, with a RUN watchdog.
// Build option: define MUL_SCHED_FIXED_PRIO_EN for fixed priority (req0 wins ties) instead of round-robin.
module mul_scheduler #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 40
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0,
  input  logic [WIDTH-1:0]     a0,
  input  logic [WIDTH-1:0]     b0,
  output logic                 done0,
  output logic [2*WIDTH-1:0]   product0,
  input  logic                 req1,
  input  logic [WIDTH-1:0]     a1,
  input  logic [WIDTH-1:0]     b1,
  output logic                 done1,
  output logic [2*WIDTH-1:0]   product1,
  output logic                 err,
  output logic                 busy,
  output logic                 mul_load,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  output logic                 mul_run,
  input  logic                 mul_ready,
  input  logic [2*WIDTH-1:0]   mul_product
);

  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t               state_reg, state_next;
  logic                 grant_reg, grant_next;
  logic [WD_W-1:0]      wd_reg, wd_next;
  logic [WIDTH-1:0]     op_a_reg, op_a_next;
  logic [WIDTH-1:0]     op_b_reg, op_b_next;
  logic [2*WIDTH-1:0]   product0_reg, product0_next;
  logic [2*WIDTH-1:0]   product1_reg, product1_next;
  logic                 err_reg, err_next;
  logic                 pick;

`ifdef MUL_SCHED_FIXED_PRIO_EN
  always_comb begin
    pick = req0 ? 1'b0 : 1'b1;
  end
`else
  logic last_grant_reg, last_grant_next;

  // On a tie, the requester that was not served last wins.
  always_comb begin
    if (req0 && req1) pick = ~last_grant_reg;
    else              pick = req0 ? 1'b0 : 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_grant_reg <= 1'b1;
    else       last_grant_reg <= last_grant_next;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      grant_reg    <= 1'b0;
      wd_reg       <= '0;
      op_a_reg     <= '0;
      op_b_reg     <= '0;
      product0_reg <= '0;
      product1_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      wd_reg       <= wd_next;
      op_a_reg     <= op_a_next;
      op_b_reg     <= op_b_next;
      product0_reg <= product0_next;
      product1_reg <= product1_next;
      err_reg      <= err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    wd_next       = wd_reg;
    op_a_next     = op_a_reg;
    op_b_next     = op_b_reg;
    product0_next = product0_reg;
    product1_next = product1_reg;
    err_next      = err_reg;
`ifndef MUL_SCHED_FIXED_PRIO_EN
    last_grant_next = last_grant_reg;
`endif
    mul_load = 1'b0;
    mul_run  = 1'b0;
    done0    = 1'b0;
    done1    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (req0 || req1) begin
          grant_next = pick;
          op_a_next  = pick ? a1 : a0;
          op_b_next  = pick ? b1 : b0;
          state_next = LOAD;
        end
      end
      LOAD: begin
        mul_load   = 1'b1;
        wd_next    = '0;
        state_next = RUN;
      end
      RUN: begin
        mul_run = 1'b1;
        wd_next = wd_reg + 1'b1;
        // A ready seen on the expiry cycle still delivers a valid product.
        if (mul_ready) begin
          if (grant_reg) product1_next = mul_product;
          else           product0_next = mul_product;
          err_next   = 1'b0;
          state_next = DONE;
        end else if (wd_reg == WD_LAST) begin
          if (grant_reg) product1_next = '0;
          else           product0_next = '0;
          err_next   = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        done0      = ~grant_reg;
        done1      = grant_reg;
        wd_next    = '0;
`ifndef MUL_SCHED_FIXED_PRIO_EN
        last_grant_next = grant_reg;
`endif
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy     = (state_reg != IDLE);
  assign mul_a    = op_a_reg;
  assign mul_b    = op_b_reg;
  assign product0 = product0_reg;
  assign product1 = product1_reg;
  assign err      = err_reg;

endmodule

// File: tb/tb_mul_scheduler.sv
// Bench for mul_scheduler: vector table, corner sequences and randomized traffic against a reference model.
module tb_mul_scheduler;
  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 40;
  localparam int NEVER   = 1000;

  logic               clk = 1'b0;
  logic               reset;
  logic               req0, req1;
  logic [WIDTH-1:0]   a0, b0, a1, b1;
  logic               done0, done1, err, busy;
  logic [2*WIDTH-1:0] product0, product1;
  logic               mul_load, mul_run, mul_ready;
  logic [WIDTH-1:0]   mul_a, mul_b;
  logic [2*WIDTH-1:0] mul_product;

  mul_scheduler #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .a0(a0), .b0(b0), .done0(done0), .product0(product0),
    .req1(req1), .a1(a1), .b1(b1), .done1(done1), .product1(product1),
    .err(err), .busy(busy),
    .mul_load(mul_load), .mul_a(mul_a), .mul_b(mul_b), .mul_run(mul_run),
    .mul_ready(mul_ready), .mul_product(mul_product)
  );

  always #5 clk = ~clk;

  // Shared multiplier stand-in: ready after 'lat' completed RUN cycles.
  int               lat = NEVER;
  int               mcnt = 0;
  logic [WIDTH-1:0] ma = '0, mb = '0;
  always @(posedge clk) begin
    if (mul_load) begin
      ma   <= mul_a;
      mb   <= mul_b;
      mcnt <= 0;
    end else if (mul_run) begin
      mcnt <= mcnt + 1;
    end
  end
  assign mul_ready   = mul_run && (mcnt == lat);
  assign mul_product = {32'b0, ma} * {32'b0, mb};

  int                 n_vec = 0;
  int                 n_fail = 0;
  logic [2*WIDTH-1:0] exp_p0 = '0, exp_p1 = '0;
  logic               exp_err = 1'b0;
  bit                 last_g = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // Follows one transaction from its mul_load to the idle cycle after done.
  // mode: 0 keep requests, 1 drop the granted request at done, 2 drop both.
  task automatic do_txn(input bit g, input logic [31:0] ea, input logic [31:0] eb,
                        input logic [63:0] ep, input bit ee, input int mode,
                        input bit pulse, input string tag);
    int cyc = 0;
    int load_cyc = -1;
    int dly;
    bit got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      cyc++;
      if (pulse && cyc == 1) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      if (mul_load) begin
        load_cyc = cyc;
        chk({tag, " mul_a"}, 64'(mul_a), 64'(ea));
        chk({tag, " mul_b"}, 64'(mul_b), 64'(eb));
      end
      if (done0 || done1) got = 1;
    end
    if (!got) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s: no done within 200 cycles, got none, expected one", tag);
      return;
    end
    dly = ee ? TIMEOUT + 1 : lat + 2;
    chk({tag, " load_cycle"}, 64'(load_cyc), 64'(1));
    chk({tag, " latency"}, 64'(cyc - load_cyc), 64'(dly));
    chk({tag, " done1_done0"}, 64'({done1, done0}), g ? 64'd2 : 64'd1);
    if (g) exp_p1 = ep;
    else   exp_p0 = ep;
    exp_err = ee;
    last_g  = g;
    chk({tag, " product0"}, product0, exp_p0);
    chk({tag, " product1"}, product1, exp_p1);
    chk({tag, " err"}, 64'(err), 64'(exp_err));
    if (mode == 1) begin
      if (g) req1 = 1'b0;
      else   req0 = 1'b0;
    end else if (mode == 2) begin
      req0 = 1'b0;
      req1 = 1'b0;
    end
    @(negedge clk);
    chk({tag, " idle done/busy"}, 64'({done1, done0, busy}), 64'd0);
    chk({tag, " err held"}, 64'(err), 64'(exp_err));
    chk({tag, " products held"}, product0 ^ product1, exp_p0 ^ exp_p1);
  endtask

  typedef struct {
    bit          r0, r1, pulse;
    logic [31:0] a0, b0, a1, b1;
    int          lat;
    bit          eg;
    logic [63:0] ep;
    bit          ee;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    vecs[0] = '{1, 1, 0, 32'd3, 32'd5, 32'hFFFF_FFFF, 32'd2, 3,  0, 64'd15, 0};
    vecs[1] = '{0, 1, 0, 32'd3, 32'd5, 32'hFFFF_FFFF, 32'd2, 10, 1, 64'h1_FFFF_FFFE, 0};
    vecs[2] = '{1, 0, 0, 32'd7, 32'd6, 32'd0, 32'd0, 32, 0, 64'd42, 0};
    vecs[3] = '{0, 1, 0, 32'd0, 32'd0, 32'h1_0000, 32'h1_0000, TIMEOUT - 1, 1, 64'h1_0000_0000, 0};
    vecs[4] = '{1, 0, 0, 32'd5, 32'd9, 32'd0, 32'd0, NEVER, 0, 64'd0, 1};
    vecs[5] = '{0, 1, 1, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1, 64'hFFFF_FFFE_0000_0001, 0};
    vecs[6] = '{1, 1, 0, 32'd2, 32'd3, 32'd4, 32'd5, 1,  0, 64'd6, 0};
    vecs[7] = '{0, 1, 0, 32'd2, 32'd3, 32'd4, 32'd5, 38, 1, 64'd20, 0};

    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset ctrl", 64'({done0, done1, err, busy, mul_load, mul_run}), 64'd0);
    chk("reset products", product0 | product1, 64'd0);
    chk("reset operands", 64'({mul_a, mul_b}), 64'd0);
    reset = 1'b0;

    foreach (vecs[k]) begin
      req0 = vecs[k].r0; req1 = vecs[k].r1;
      a0 = vecs[k].a0; b0 = vecs[k].b0; a1 = vecs[k].a1; b1 = vecs[k].b1;
      lat = vecs[k].lat;
      do_txn(vecs[k].eg, vecs[k].eg ? vecs[k].a1 : vecs[k].a0, vecs[k].eg ? vecs[k].b1 : vecs[k].b0,
             vecs[k].ep, vecs[k].ee, 1, vecs[k].pulse, $sformatf("vec%0d", k));
      req0 = 1'b0; req1 = 1'b0;
    end

    // Reset in the middle of RUN: outputs clear at once, no done afterwards.
    lat = NEVER;
    req1 = 1'b1; a1 = 32'd123; b1 = 32'd456;
    for (int i = 0; i < 20 && !mul_run; i++) @(negedge clk);
    chk("midrun reached RUN", 64'(mul_run), 64'd1);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrun ctrl", 64'({done0, done1, err, busy, mul_load, mul_run}), 64'd0);
    chk("midrun products", product0 | product1, 64'd0);
    chk("midrun operands", 64'({mul_a, mul_b}), 64'd0);
    req1 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_p0 = '0; exp_p1 = '0; exp_err = 1'b0; last_g = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post reset quiet", 64'({done0, done1, busy, mul_run}), 64'd0);
    end

    // Both requesters held: round-robin alternates, fixed priority keeps serving 0.
    a0 = 32'd11; b0 = 32'd13; a1 = 32'd17; b1 = 32'd19;
    lat = 4;
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bit eg;
`ifdef MUL_SCHED_FIXED_PRIO_EN
      eg = 1'b0;
`else
      eg = k[0];
`endif
      do_txn(eg, eg ? a1 : a0, eg ? b1 : b0, eg ? 64'd323 : 64'd143, 0, 0, 0,
             $sformatf("b2b%0d", k));
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);

    // Randomized traffic against the reference model.
    for (int k = 0; k < 24; k++) begin
      int          pat;
      bit          g;
      logic [31:0] ea, eb;
      logic [63:0] ep;
      bit          ee;
      pat = $urandom_range(1, 3);
      a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
      lat = ($urandom_range(0, 5) == 0) ? NEVER : $urandom_range(0, TIMEOUT - 1);
      if (pat == 1)      g = 1'b0;
      else if (pat == 2) g = 1'b1;
      else begin
`ifdef MUL_SCHED_FIXED_PRIO_EN
        g = 1'b0;
`else
        g = ~last_g;
`endif
      end
      ea = g ? a1 : a0;
      eb = g ? b1 : b0;
      ee = (lat >= TIMEOUT);
      ep = ee ? 64'd0 : {32'b0, ea} * {32'b0, eb};
      req0 = pat[0]; req1 = pat[1];
      do_txn(g, ea, eb, ep, ee, 2, ($urandom_range(0, 3) == 0), $sformatf("rnd%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
